// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that runs a single-port sync RAM as DEPTH-word storage, plus one output register word.
// Push to rd_valid takes 2 edges; reads take the RAM port first, dropping wr_ready while a read issues or when full.
module ram_fifo_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   level,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addres,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);
   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0]   FULL_CNT = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   ram_count;
   logic              out_valid;
   logic              read_issue;
   logic              write_issue;
   logic              pop;

   // A read is only worth issuing when its result has somewhere to land on the capture edge.
   assign read_issue  = !rst && (state == IDLE) && (ram_count != '0) && (!out_valid || rd_ready);
   assign wr_ready    = !rst && (ram_count != FULL_CNT) && !read_issue;
   assign write_issue = wr_valid && wr_ready;
   assign pop         = out_valid && rd_ready;
   assign rd_valid    = out_valid;

   assign level = ram_count
                + {{ADDR_W{1'b0}}, out_valid}
                + {{ADDR_W{1'b0}}, (state == RD_WAIT)};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (read_issue) state_nxt = RD_WAIT;
         RD_WAIT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_addres  = rd_ptr;
      ram_data_in = wr_data;
      if (read_issue) begin
         ram_en = 1'b1;
      end else if (write_issue) begin
         ram_en     = 1'b1;
         ram_we     = 1'b1;
         ram_addres = wr_ptr;
      end
   end

   // Read and write issue are mutually exclusive, so the count moves by at most one.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ram_count <= '0;
      end else begin
         if (read_issue) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            ram_count <= ram_count - CNT_ONE;
         end else if (write_issue) begin
            wr_ptr    <= wr_ptr + PTR_ONE;
            ram_count <= ram_count + CNT_ONE;
         end
      end
   end

   // out_valid is always low in RD_WAIT, so a capture never collides with a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         rd_data   <= '0;
      end else if (state == RD_WAIT) begin
         out_valid <= 1'b1;
         rd_data   <= ram_data_out;
      end else if (pop) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO reference model.
module tb_ram_fifo_ctrl;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 2**ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_valid;
   logic              wr_ready;
   logic [DATA_W-1:0] wr_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W:0]   level;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addres;
   logic [DATA_W-1:0] ram_data_in;
   logic [DATA_W-1:0] ram_data_out;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] model_q [$];
   int n_pass    = 0;
   int n_total   = 0;
   int pop_count = 0;

   always #5 clk = ~clk;

   ram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_data      (wr_data),
      .rd_valid     (rd_valid),
      .rd_ready     (rd_ready),
      .rd_data      (rd_data),
      .level        (level),
      .ram_en       (ram_en),
      .ram_we       (ram_we),
      .ram_addres   (ram_addres),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out)
   );

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addres] <= ram_data_in;
         else        ram_data_out    <= mem[ram_addres];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Inputs change only at posedge+1, so the negedge view equals what the next edge samples.
   always @(negedge clk) begin
      if (rst) begin
         model_q.delete();
         check("rst_ram_en", 32'(ram_en), 0);
         check("rst_wr_ready", 32'(wr_ready), 0);
      end else begin
         check("level_model", 32'(level), model_q.size());
         check("level_max", 32'(level <= 4'd9), 1);
         check("wr_op", 32'(ram_en && ram_we), 32'(wr_valid && wr_ready));
         if (ram_en && ram_we) check("wr_data_pass", 32'(ram_data_in), 32'(wr_data));
         if (rd_valid && rd_ready) begin
            check("pop_nonempty", 32'(model_q.size() != 0), 1);
            if (model_q.size() != 0) begin
               check("pop_data", 32'(rd_data), 32'(model_q[0]));
               void'(model_q.pop_front());
            end
            pop_count++;
         end
         if (wr_valid && wr_ready) model_q.push_back(wr_data);
      end
   end

   task automatic push_word(input logic [7:0] d, input int budget, output bit ok);
      ok       = 1'b0;
      wr_valid = 1'b1;
      wr_data  = d;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (wr_ready) ok = 1'b1;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      wr_valid = 1'b0;
   endtask

   task automatic wait_empty(input int budget, output int cyc);
      bit hit;
      hit = 1'b0;
      cyc = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!rd_valid && level == '0) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      if (hit) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      bit ok;
      bit acc_now;
      int acc;
      int cyc;
      int pops0;

      rst      = 1'b1;
      wr_valid = 1'b1;
      wr_data  = 8'h77;
      rd_ready = 1'b0;

      // Reset held for two edges with a push offered.
      @(negedge clk);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_level", 32'(level), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_wr_ready_dir", 32'(wr_ready), 0);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      wr_valid = 1'b0;
      @(negedge clk);
      check("post_rst_level", 32'(level), 0);
      check("post_rst_rd_valid", 32'(rd_valid), 0);

      // Single word latency.
      @(posedge clk);
      #1;
      wr_valid = 1'b1;
      wr_data  = 8'h2A;
      @(negedge clk);
      check("single_wr_ready", 32'(wr_ready), 1);
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      @(negedge clk);
      check("single_ram_en", 32'(ram_en), 1);
      check("single_ram_we", 32'(ram_we), 0);
      check("single_ram_addr", 32'(ram_addres), 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("single_rd_valid", 32'(rd_valid), 1);
      check("single_rd_data", 32'(rd_data), 'h2A);
      check("single_level", 32'(level), 1);
      @(posedge clk);
      #1;
      rd_ready = 1'b1;
      wait_empty(10, cyc);
      check("single_drained", 32'(level), 0);
      rd_ready = 1'b0;

      // Fill to 9 words; the 10th must be refused.
      acc = 0;
      for (int v = 1; v <= 10; v++) begin
         push_word(8'(v), 20, ok);
         if (ok) acc++;
      end
      check("fill_accepted", acc, 9);
      check("fill_0A_blocked", 32'(ok), 0);
      @(negedge clk);
      check("fill_level", 32'(level), 9);
      check("fill_head", 32'(rd_data), 'h01);
      check("fill_wr_ready", 32'(wr_ready), 0);
      @(posedge clk);
      #1;

      // Drain from full: 9 pops, one every 2 cycles.
      pops0    = pop_count;
      rd_ready = 1'b1;
      wait_empty(40, cyc);
      check("drain_cycles", cyc, 17);
      check("drain_pops", pop_count - pops0, 9);

      // 20 words through the FIFO with rd_ready high, wrapping pointers.
      pops0 = pop_count;
      acc   = 0;
      for (int k = 0; k < 20; k++) begin
         push_word(8'($urandom), 20, ok);
         if (ok) acc++;
      end
      check("wrap_accepted", acc, 20);
      wait_empty(80, cyc);
      check("wrap_pops", pop_count - pops0, 20);
      check("wrap_level", 32'(level), 0);

      // Random simultaneous traffic.
      wr_valid = 1'b1;
      wr_data  = 8'($urandom);
      rd_ready = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         acc_now = wr_valid && wr_ready;
         @(posedge clk);
         #1;
         if (acc_now || !wr_valid) begin
            wr_valid = ($urandom_range(0, 4) != 0);
            wr_data  = 8'($urandom);
         end
         rd_ready = ($urandom_range(0, 3) != 0);
      end
      wr_valid = 1'b0;
      rd_ready = 1'b1;
      wait_empty(60, cyc);
      check("rand_drain_level", 32'(level), 0);

      // Reset landing on an RD_WAIT cycle with 3 words held.
      rd_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push_word(8'('h30 + k), 20, ok);
      end
      @(negedge clk);
      check("mid_pre_level", 32'(level), 4);
      check("mid_pre_rd_valid", 32'(rd_valid), 1);
      @(posedge clk);
      #1;
      rd_ready = 1'b1;
      @(negedge clk);
      check("mid_read_en", 32'(ram_en && !ram_we), 1);
      @(posedge clk);
      #1;
      rd_ready = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check("mid_rdwait_level", 32'(level), 3);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_post_rd_valid", 32'(rd_valid), 0);
      check("mid_post_level", 32'(level), 0);
      check("mid_post_rd_data", 32'(rd_data), 0);
      @(posedge clk);
      #1;
      push_word(8'h55, 20, ok);
      check("mid_push_55", 32'(ok), 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rd_valid) break;
         @(posedge clk);
         #1;
      end
      check("mid_first_valid", 32'(rd_valid), 1);
      check("mid_first_data", 32'(rd_data), 'h55);
      @(posedge clk);
      #1;
      rd_ready = 1'b1;
      wait_empty(20, cyc);
      check("final_level", 32'(level), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
